wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
Wishbone classic single-transfer bus master. It issues the reads and writes that the board's register slaves (system block, scratchpads, user registers) respond to. A simple valid/ready command port accepts one transaction at a time; the block runs one wb_cyc/wb_stb cycle and returns read data plus a completion status on a valid/ready response port. A bus timeout guarantees forward progress when no slave acknowledges.

Parameters:
TIMEOUT, 255, maximum cycles wb_stb_o stays asserted without ack/err; legal range 2..65535
TO_W, 16, width of the internal timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command presented
cmd_ready  out  1  block can accept a command (high only in IDLE and not in reset)
cmd_we  in  1  1 = write, 0 = read
cmd_sel  in  4  byte enables
cmd_adr  in  32  byte address
cmd_dat  in  32  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_dat  out  32  read data (0 for writes, err and timeout)
rsp_status  out  2  00 ack, 01 err, 10 timeout, 11 unused
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte selects
wb_adr_o  out  32  address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data from slave
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error

Behaviour:
- Reset: state IDLE. wb_cyc_o, wb_stb_o, wb_we_o = 0. wb_sel_o, wb_adr_o, wb_dat_o = 0. rsp_valid = 0, rsp_dat = 0, rsp_status = 00, timeout counter = 0. cmd_ready = 0 while wb_rst_i is high.
- All wb_* outputs and rsp_* outputs are registered. cmd_ready = (state == IDLE) && !wb_rst_i.
- IDLE: when cmd_valid && cmd_ready at an edge, latch we/sel/adr/dat onto the wb_* outputs, set cyc=stb=1, clear counter, go to BUS. Bus signals are high starting the cycle after acceptance.
- BUS: cyc, stb, we, sel, adr and dat are held stable. Each cycle, sample ack/err:
  - ack_i = 1: rsp_dat = wb_dat_i for a read, 0 for a write; status = 00. Go to RESP.
  - err_i = 1 with ack_i = 0: rsp_dat = 0, status = 01. Go to RESP.
  - ack_i and err_i both high: ack wins.
  - Neither asserted and counter == TIMEOUT-1: rsp_dat = 0, status = 10. Go to RESP.
  - Otherwise counter increments.
  - stb is therefore high for at most TIMEOUT cycles.
- Leaving BUS: cyc=stb=0 and rsp_valid=1 in the same next cycle. wb_we_o/wb_sel_o return to 0. Address and data may hold their last values.
- RESP: rsp_valid, rsp_dat and rsp_status are held until rsp_ready is sampled high; then rsp_valid=0 and the state goes to IDLE. The next command can be accepted in the cycle after the return to IDLE, so there are no back-to-back cycles without an idle cycle between them.
- ack_i and err_i outside BUS are ignored. This covers the second ack that a registered-ack slave produces one cycle late.
- Latency against a slave with a one-cycle registered ack:
  - acceptance edge = cycle 0
  - cyc/stb high in cycles 1-2
  - ack seen in cycle 2
  - rsp_valid high in cycle 3
- Reset mid-operation (BUS or RESP): cyc/stb drop at the reset edge, no response is issued, the state returns to IDLE, and any pending response is discarded.

Test Plan:
- Read with a registered-ack slave returning 32'hDEADBEEF at adr 0x10 -> cyc/stb high exactly 2 cycles; rsp_valid in cycle 3; rsp_dat=DEADBEEF; status=00.
- Write adr 0x14, dat 0x12345678, sel 4'b0101 -> wb_we_o=1, wb_sel_o=0101, wb_dat_o=12345678 stable for the whole cycle; rsp_dat=0; status=00; slave's late second ack produces no extra response.
- Slave never responds, TIMEOUT=8 -> stb high exactly 8 cycles; status=10; rsp_dat=0; cmd_ready stays 0 throughout.
- err_i and ack_i asserted together on the first BUS cycle -> status=00; err_i alone -> status=01, rsp_dat=0.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_dat and rsp_status stable for all 5 cycles; cmd_ready=0; a cmd_valid presented meanwhile is not accepted until the cycle after rsp_ready=1.
- wb_rst_i pulsed in the 2nd BUS cycle -> cyc/stb=0 the next cycle; rsp_valid never asserts; cmd_ready=1 in the first cycle after reset releases.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone classic signals of the single-transfer bus master.
// The master modport is the DUT view; the slave modport is the view of whatever drives it.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: one command per bus cycle, response held until rsp_ready.
// Response appears the cycle after ack/err/timeout is sampled; commands stall (cmd_ready low) outside IDLE.
module wb_cmd_master #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  assign bus.cmd_ready  = (state_q == IDLE) && !wb_rst_i;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = stb_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dat    = rsp_dat_q;
  assign bus.rsp_status = rsp_status_q;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack takes priority over err when a slave raises both
        if (bus.wb_ack_i || bus.wb_err_i || cnt_q == TO_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          if (bus.wb_ack_i) begin
            rsp_dat_d    = we_q ? 32'd0 : bus.wb_dat_i;
            rsp_status_d = 2'b00;
          end else if (bus.wb_err_i) begin
            rsp_dat_d    = 32'd0;
            rsp_status_d = 2'b01;
          end else begin
            rsp_dat_d    = 32'd0;
            rsp_status_d = 2'b10;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
